instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Drives the next-PC side of the program counter: consumes `instr_addr` and produces `next_pc` and `no_update`.
- Fetches each instruction word from instruction memory over a valid/ready request plus response-valid interface.
- Holds each fetched instruction for the decoder until accepted.
- Handles control-flow redirects and discards stale memory responses.

Parameters:
- ADDR_WIDTH, 32, width of instr_addr, next_pc, mem_addr, redirect_pc.
- DATA_WIDTH, 32, instruction word width.
- INSTR_BYTES, 4, PC increment per sequential fetch.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_addr  in  ADDR_WIDTH  current PC from the program counter.
- next_pc  out  ADDR_WIDTH  PC value loaded at the next edge when no_update=0.
- no_update  out  1  1 = program counter holds its value.
- mem_req  out  1  fetch request valid.
- mem_addr  out  ADDR_WIDTH  fetch address; always equals instr_addr.
- mem_ready  in  1  memory accepts request this cycle (mem_req && mem_ready).
- mem_rvalid  in  1  response valid; exactly one per accepted request, at least 1 cycle after acceptance.
- mem_rdata  in  DATA_WIDTH  instruction word.
- instr_valid  out  1  instr/instr_pc valid to the decoder.
- instr  out  DATA_WIDTH  registered instruction.
- instr_pc  out  ADDR_WIDTH  address the instruction was fetched from.
- decode_ready  in  1  decoder accepts instr this cycle.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- fetch_fault  out  1  misaligned fetch address; sticky.

Behaviour:
- States: IDLE, REQ, WAIT, HOLD, DRAIN, FAULT.
- Reset (async): state=IDLE, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0.
- Default outputs: no_update=1, next_pc=instr_addr+INSTR_BYTES (mod 2^ADDR_WIDTH, wraps silently).
- next_pc is combinational; every other output is registered or state-decoded.
- IDLE: always advances to REQ next cycle; mem_req=0.
- REQ:
  - If instr_addr[1:0]!=0: mem_req=0, go to FAULT.
  - Otherwise mem_req=1.
  - On mem_ready: capture instr_pc<=instr_addr and go to WAIT.
- WAIT: mem_req=0. On mem_rvalid: instr<=mem_rdata, instr_valid<=1, go to HOLD.
- HOLD: instr_valid=1. On decode_ready: no_update=0, next_pc=instr_addr+INSTR_BYTES, instr_valid<=0, go to REQ. Minimum throughput: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect (priority over all of the above, any state except IDLE): no_update=0, next_pc=redirect_pc, and instr_valid<=0 at the edge.
  - In REQ without mem_ready: stay REQ; mem_req may drop for that cycle.
  - In REQ with mem_ready, or in WAIT without mem_rvalid: go to DRAIN.
  - In WAIT with mem_rvalid the same cycle: discard data, go to REQ.
  - In HOLD: the held instruction is dropped even if decode_ready=1; go to REQ.
  - In DRAIN: stay DRAIN.
  - In FAULT: clear fetch_fault, go to REQ.
- DRAIN: mem_req=0, no_update=1 unless redirecting. On mem_rvalid: data discarded, go to REQ. Exactly one outstanding response is drained.
- FAULT: fetch_fault=1, mem_req=0, no_update=1. Exit only via redirect.
- Reset mid-transaction: state to IDLE immediately. Memory must also be reset, so no stale response arrives afterwards.
- Redirect during IDLE is ignored. The block never asserts mem_req while a response is outstanding.

Decomposition:
- Shared package:
  - fetch-state enum (IDLE..FAULT)
  - INSTR_BYTES constant
  - NOP encoding 32'h00000013, used by the bench for filler
- Single module; no sub-module. Next-PC select is a 2:1 mux inlined in the FSM output logic.

Test Plan:
- Reset with instr_addr=0, mem_ready=1, rvalid 1 cycle after accept, rdata=32'h00500093, decode_ready=1 -> mem_req at cycle 1; instr_valid with instr=32'h00500093 and instr_pc=0 at cycle 3; next_pc=4, no_update=0 in that cycle.
- mem_ready held 0 for 3 cycles at instr_addr=8 -> mem_req stays 1 and no_update stays 1 throughout; accept on the 4th cycle; instr_pc=8.
- decode_ready=0 for 4 cycles in HOLD -> instr and instr_valid stable, no_update=1; release -> next_pc=instr_addr+4 for one cycle.
- redirect_valid with redirect_pc=32'h100 in WAIT (rvalid 2 cycles later, rdata=32'hDEADBEEF) -> next_pc=32'h100, no_update=0 in the redirect cycle; DEADBEEF never appears on instr; next mem_addr=32'h100.
- instr_addr=32'h6 in REQ -> mem_req=0, fetch_fault=1 until redirect_pc=32'h20; then fault clears and fetch resumes at 32'h20.
- instr_addr=32'hFFFFFFFC, sequential accept -> next_pc=0 (wrap).

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

    // Byte distance between consecutive sequential fetches.
    localparam int INSTR_BYTES = 4;

    // Canonical RISC-V NOP (addi x0, x0, 0); handy as filler data.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_FAULT = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory request/response, decoder hand-off and redirect bundle.
// Latency: n/a (wiring only).
// Backpressure: mem_ready stalls requests, decode_ready stalls the hand-off.
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  decode_ready;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    // Fetch unit side.
    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc,
        input  mem_ready, mem_rvalid, mem_rdata, decode_ready,
               redirect_valid, redirect_pc
    );

    // Memory / decoder / branch-unit side.
    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc,
        output mem_ready, mem_rvalid, mem_rdata, decode_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetches one instruction per PC, holds it for decode, steers the PC (seq or redirect).
// Latency: request->instr_valid 2 cycles min (REQ, WAIT, HOLD => 1 instr / 3 cycles).
// Backpressure: stalls in REQ on !mem_ready, in HOLD on !decode_ready; PC held meanwhile.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_BYTES = instr_fetch_unit_pkg::INSTR_BYTES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  no_update,
    output logic                  fetch_fault,
    instr_fetch_unit_if.master    bus
);
    import instr_fetch_unit_pkg::*;

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  fetch_fault_q, fetch_fault_d;

    logic                  misaligned;
    logic                  redirect_act;
    logic                  sel_redirect;
    logic                  mem_req_c;
    logic [ADDR_WIDTH-1:0] seq_pc;

    // PC + increment; wraps modulo 2^ADDR_WIDTH by construction.
    assign seq_pc       = instr_addr + ADDR_WIDTH'(INSTR_BYTES);
    assign misaligned   = (instr_addr[1:0] != 2'b00);
    // A redirect before the first request has nothing to cancel, so IDLE ignores it.
    assign redirect_act = bus.redirect_valid && (state_q != ST_IDLE);

    // Next-state, captured data and PC-steering decisions.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        no_update     = 1'b1;
        sel_redirect  = 1'b0;
        mem_req_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                mem_req_c = !misaligned;
                if (redirect_act) begin
                    // An accepted request still owes us one response.
                    if (mem_req_c && bus.mem_ready) begin
                        state_d = ST_DRAIN;
                    end
                end else if (misaligned) begin
                    state_d = ST_FAULT;
                end else if (bus.mem_ready) begin
                    instr_pc_d = instr_addr;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (redirect_act) begin
                        state_d = ST_REQ;
                    end else begin
                        instr_d       = bus.mem_rdata;
                        instr_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end
                end else if (redirect_act) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (redirect_act) begin
                    state_d = ST_REQ;
                end else if (bus.decode_ready) begin
                    no_update     = 1'b0;
                    instr_valid_d = 1'b0;
                    state_d       = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the stale response lands, even under a new
                // redirect, otherwise no further response would ever arrive.
                if (bus.mem_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            ST_FAULT: begin
                if (redirect_act) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Redirect outranks every per-state decision above.
        if (redirect_act) begin
            no_update     = 1'b0;
            sel_redirect  = 1'b1;
            instr_valid_d = 1'b0;
        end

        fetch_fault_d = (state_d == ST_FAULT);
    end

    // 2:1 next-PC select: redirect target or sequential successor.
    always_comb begin
        next_pc = sel_redirect ? bus.redirect_pc : seq_pc;
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    assign bus.mem_req     = mem_req_c;
    assign bus.mem_addr    = instr_addr;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign fetch_fault     = fetch_fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed cycle-by-cycle bench for instr_fetch_unit.
// Latency: one vector per clock, outputs sampled 1 ns after the falling edge.
// Backpressure: mem_ready/decode_ready driven explicitly per vector.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam logic [31:0] I0   = 32'h0050_0093;
    localparam logic [31:0] I1   = 32'h0010_0113;
    localparam logic [31:0] I2   = 32'h0020_8193;
    localparam logic [31:0] I3   = 32'h0000_0011;

    typedef struct {
        logic [31:0] addr;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        dr;
        logic        rdr;
        logic [31:0] rpc;
        logic        e_req;
        logic        e_nu;
        logic [31:0] e_np;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_ff;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] instr_addr;
    logic [31:0] next_pc;
    logic        no_update;
    logic        fetch_fault;

    int checks;
    int errors;

    instr_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    instr_fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .INSTR_BYTES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_addr (instr_addr),
        .next_pc    (next_pc),
        .no_update  (no_update),
        .fetch_fault(fetch_fault),
        .bus        (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [31:0] addr, input logic rdy, input logic rv, input logic [31:0] rd,
        input logic dr, input logic rdr, input logic [31:0] rpc,
        input logic e_req, input logic e_nu, input logic [31:0] e_np, input logic e_iv,
        input logic [31:0] e_instr, input logic [31:0] e_ipc, input logic e_ff);
        vec_t v;
        v.addr = addr; v.rdy = rdy; v.rv = rv; v.rd = rd; v.dr = dr; v.rdr = rdr; v.rpc = rpc;
        v.e_req = e_req; v.e_nu = e_nu; v.e_np = e_np; v.e_iv = e_iv;
        v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_ff = e_ff;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        instr_addr         = v.addr;
        bus.mem_ready      = v.rdy;
        bus.mem_rvalid     = v.rv;
        bus.mem_rdata      = v.rd;
        bus.decode_ready   = v.dr;
        bus.redirect_valid = v.rdr;
        bus.redirect_pc    = v.rpc;
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        chk({tag, ".mem_req"},     32'(bus.mem_req),     32'(v.e_req));
        chk({tag, ".mem_addr"},    bus.mem_addr,         v.addr);
        chk({tag, ".no_update"},   32'(no_update),       32'(v.e_nu));
        chk({tag, ".next_pc"},     next_pc,              v.e_np);
        chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(v.e_iv));
        chk({tag, ".instr"},       bus.instr,            v.e_instr);
        chk({tag, ".instr_pc"},    bus.instr_pc,         v.e_ipc);
        chk({tag, ".fetch_fault"}, 32'(fetch_fault),     32'(v.e_ff));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        drive(v);
        #1;
        check_vec(v, tag);
    endtask

    vec_t tv[$];
    vec_t v;

    initial begin
        checks = 0;
        errors = 0;

        //          addr          rdy rv rd           dr rdr rpc       | req nu np            iv instr      ipc           ff
        // Basic fetch from 0, decoder always ready.
        tv.push_back(mk(32'h0,        1, 0, 32'h0,        1, 0, 32'h0,   0, 1, 32'h4,        0, 32'h0, 32'h0,        0));
        tv.push_back(mk(32'h0,        1, 0, 32'h0,        1, 0, 32'h0,   1, 1, 32'h4,        0, 32'h0, 32'h0,        0));
        tv.push_back(mk(32'h0,        0, 1, I0,           1, 0, 32'h0,   0, 1, 32'h4,        0, 32'h0, 32'h0,        0));
        tv.push_back(mk(32'h0,        0, 0, 32'h0,        1, 0, 32'h0,   0, 0, 32'h4,        1, I0,    32'h0,        0));
        // Memory not ready for 3 cycles at PC 8.
        for (int k = 0; k < 3; k++)
            tv.push_back(mk(32'h8,    0, 0, 32'h0,        1, 0, 32'h0,   1, 1, 32'hC,        0, I0,    32'h0,        0));
        tv.push_back(mk(32'h8,        1, 0, 32'h0,        1, 0, 32'h0,   1, 1, 32'hC,        0, I0,    32'h0,        0));
        tv.push_back(mk(32'h8,        0, 1, I1,           0, 0, 32'h0,   0, 1, 32'hC,        0, I0,    32'h8,        0));
        // Decoder stalls 4 cycles in HOLD, then accepts.
        for (int k = 0; k < 4; k++)
            tv.push_back(mk(32'h8,    0, 0, 32'h0,        0, 0, 32'h0,   0, 1, 32'hC,        1, I1,    32'h8,        0));
        tv.push_back(mk(32'h8,        0, 0, 32'h0,        1, 0, 32'h0,   0, 0, 32'hC,        1, I1,    32'h8,        0));
        // Redirect in WAIT; stale DEADBEEF drained two cycles later.
        tv.push_back(mk(32'hC,        1, 0, 32'h0,        1, 0, 32'h0,   1, 1, 32'h10,       0, I1,    32'h8,        0));
        tv.push_back(mk(32'hC,        0, 0, 32'h0,        1, 1, 32'h100, 0, 0, 32'h100,      0, I1,    32'hC,        0));
        tv.push_back(mk(32'h100,      0, 0, 32'h0,        1, 0, 32'h0,   0, 1, 32'h104,      0, I1,    32'hC,        0));
        tv.push_back(mk(32'h100,      0, 1, 32'hDEADBEEF, 1, 0, 32'h0,   0, 1, 32'h104,      0, I1,    32'hC,        0));
        tv.push_back(mk(32'h100,      0, 0, 32'h0,        1, 0, 32'h0,   1, 1, 32'h104,      0, I1,    32'hC,        0));
        // Misaligned PC faults until redirected to 0x20.
        tv.push_back(mk(32'h6,        1, 0, 32'h0,        1, 0, 32'h0,   0, 1, 32'hA,        0, I1,    32'hC,        0));
        tv.push_back(mk(32'h6,        1, 0, 32'h0,        1, 0, 32'h0,   0, 1, 32'hA,        0, I1,    32'hC,        1));
        tv.push_back(mk(32'h6,        1, 0, 32'h0,        1, 0, 32'h0,   0, 1, 32'hA,        0, I1,    32'hC,        1));
        tv.push_back(mk(32'h6,        1, 0, 32'h0,        1, 1, 32'h20,  0, 0, 32'h20,       0, I1,    32'hC,        1));
        tv.push_back(mk(32'h20,       1, 0, 32'h0,        1, 0, 32'h0,   1, 1, 32'h24,       0, I1,    32'hC,        0));
        tv.push_back(mk(32'h20,       0, 1, NOP_INSTR,    1, 0, 32'h0,   0, 1, 32'h24,       0, I1,    32'h20,       0));
        tv.push_back(mk(32'h20,       0, 0, 32'h0,        1, 0, 32'h0,   0, 0, 32'h24,       1, NOP_INSTR, 32'h20,   0));
        // PC wrap at the top of the address space.
        tv.push_back(mk(32'hFFFFFFFC, 1, 0, 32'h0,        1, 0, 32'h0,   1, 1, 32'h0,        0, NOP_INSTR, 32'h20,   0));
        tv.push_back(mk(32'hFFFFFFFC, 0, 1, I2,           1, 0, 32'h0,   0, 1, 32'h0,        0, NOP_INSTR, 32'hFFFFFFFC, 0));
        tv.push_back(mk(32'hFFFFFFFC, 0, 0, 32'h0,        1, 0, 32'h0,   0, 0, 32'h0,        1, I2,    32'hFFFFFFFC, 0));
        // Redirect in HOLD drops the instruction despite decode_ready.
        tv.push_back(mk(32'h0,        1, 0, 32'h0,        0, 0, 32'h0,   1, 1, 32'h4,        0, I2,    32'hFFFFFFFC, 0));
        tv.push_back(mk(32'h0,        0, 1, I3,           0, 0, 32'h0,   0, 1, 32'h4,        0, I2,    32'h0,        0));
        tv.push_back(mk(32'h0,        0, 0, 32'h0,        1, 1, 32'h40,  0, 0, 32'h40,       1, I3,    32'h0,        0));
        tv.push_back(mk(32'h40,       0, 0, 32'h0,        1, 0, 32'h0,   1, 1, 32'h44,       0, I3,    32'h0,        0));
        // Redirect in WAIT coinciding with rvalid: data discarded, straight to REQ.
        tv.push_back(mk(32'h40,       1, 0, 32'h0,        1, 0, 32'h0,   1, 1, 32'h44,       0, I3,    32'h0,        0));
        tv.push_back(mk(32'h40,       0, 1, 32'h00000BAD, 1, 1, 32'h80,  0, 0, 32'h80,       0, I3,    32'h40,       0));
        tv.push_back(mk(32'h80,       0, 0, 32'h0,        1, 0, 32'h0,   1, 1, 32'h84,       0, I3,    32'h40,       0));
        tv.push_back(mk(32'h80,       1, 0, 32'h0,        1, 0, 32'h0,   1, 1, 32'h84,       0, I3,    32'h40,       0));

        // Reset state.
        reset = 1'b1;
        v = mk(32'h0, 1, 0, 32'h0, 1, 0, 32'h0, 0, 1, 32'h4, 0, 32'h0, 32'h0, 0);
        drive(v);
        repeat (2) @(negedge clk);
        #1;
        check_vec(v, "reset");

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < tv.size(); i++) begin
            run_vec(tv[i], $sformatf("v%0d", i));
            @(negedge clk);
        end

        // DUT now sits in WAIT; async reset mid-transaction returns to IDLE at once.
        v = mk(32'h80, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1, 32'h84, 0, 32'h0, 32'h0, 0);
        drive(v);
        reset = 1'b1;
        #1;
        check_vec(v, "midreset");
        @(negedge clk);
        reset = 1'b0;
        // Redirect while IDLE is ignored.
        run_vec(mk(32'h80, 1, 0, 32'h0, 1, 1, 32'h200, 0, 1, 32'h84, 0, 32'h0, 32'h0, 0), "idle_redir");
        @(negedge clk);
        run_vec(mk(32'h80, 0, 0, 32'h0, 1, 0, 32'h0,   1, 1, 32'h84, 0, 32'h0, 32'h0, 0), "post_reset_req");
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
